// File: rtl/kf_spi_host_if.sv
// SPI bus between the Kalman-filter host and its slave.
// The master drives sck, mosi and ss; the slave returns miso.
interface kf_spi_host_if;
    logic sck;
    logic mosi;
    logic miso;
    logic ss;

    modport master (output sck, output mosi, output ss, input miso);
    modport slave  (input sck, input mosi, input ss, output miso);
endinterface

// File: rtl/kf_spi_host.sv
// SPI master for the Kalman-filter slave link: sends a start bit and the
// configuration words, then reads one result word per slave_ready.
module kf_spi_host #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int N_CFG   = 5
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_cfg,
    input  logic [DATA_W-1:0] cfg_data,
    output logic [2:0]        cfg_idx,
    input  logic              slave_ready,
    kf_spi_host_if.master     spi,
    output logic              busy,
    output logic              cfg_done,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        CFG_START,
        CFG_SHIFT,
        CFG_GAP,
        CFG_DONE,
        RD_SHIFT,
        RD_DONE
    } state_t;

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(DATA_W);

    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_END  = BW'(DATA_W - 1);
    localparam logic [2:0]    LAST_IDX = 3'(N_CFG - 1);
    localparam logic [2:0]    NO_IDX   = 3'b111;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [BW-1:0]       bit_q;
    logic [DATA_W-1:0]   shift_q;
    logic                sck_q;
    logic                mosi_q;
    logic                ss_q;
    logic                busy_q;
    logic                done_q;
    logic [2:0]          idx_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                load_q;
    logic                first_q;

    logic                sck_run;
    logic                tc;
    logic                rise;
    logic                fall;

    assign sck_run = (state_q == CFG_START) ||
                     (state_q == CFG_SHIFT) ||
                     (state_q == RD_SHIFT);
    assign tc      = (cnt_q == HALF_END);
    assign rise    = sck_run && tc && !sck_q;
    assign fall    = sck_run && tc && sck_q;
    assign cnt_d   = tc ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ss_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            idx_q      <= NO_IDX;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            load_q     <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (sck_run) begin
                cnt_q <= cnt_d;
                if (tc) sck_q <= !sck_q;
            end
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    sck_q <= 1'b0;
                    if (start_cfg && !done_q) begin
                        state_q <= CFG_START;
                        ss_q    <= 1'b1;
                        mosi_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (slave_ready && done_q) begin
                        state_q <= RD_SHIFT;
                        ss_q    <= 1'b1;
                        mosi_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                CFG_START: begin
                    if (fall) begin
                        state_q <= CFG_SHIFT;
                        mosi_q  <= 1'b0;
                        idx_q   <= '0;
                        load_q  <= 1'b1;
                    end
                end
                CFG_SHIFT: begin
                    // Word is captured once, so later cfg_data changes are ignored
                    if (load_q) begin
                        shift_q <= cfg_data;
                        mosi_q  <= cfg_data[DATA_W-1];
                        load_q  <= 1'b0;
                    end
                    if (fall) begin
                        if (bit_q == BIT_END) begin
                            state_q <= CFG_GAP;
                            bit_q   <= '0;
                            mosi_q  <= 1'b0;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                            mosi_q  <= shift_q[DATA_W-2];
                        end
                    end
                end
                CFG_GAP: begin
                    if (cnt_q == GAP_END) begin
                        cnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= CFG_DONE;
                        end else begin
                            state_q <= CFG_SHIFT;
                            idx_q   <= idx_q + 3'd1;
                            load_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CFG_DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    idx_q   <= NO_IDX;
                    ss_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
                RD_SHIFT: begin
                    if (rise) shift_q <= {shift_q[DATA_W-2:0], spi.miso};
                    if (fall) begin
                        if (bit_q == BIT_END) begin
                            state_q <= RD_DONE;
                            bit_q   <= '0;
                            first_q <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                RD_DONE: begin
                    if (first_q) begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                        first_q    <= 1'b0;
                    end
                    // Leave only once the slave drops ready, so a word is read once
                    if (!slave_ready) begin
                        state_q <= IDLE;
                        ss_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ss_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign spi.sck  = sck_q;
    assign spi.mosi = mosi_q;
    assign spi.ss   = ss_q;
    assign busy     = busy_q;
    assign cfg_done = done_q;
    assign cfg_idx  = idx_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_kf_spi_host.sv
// Bench for kf_spi_host: table and random configuration/readout runs
// checked against a bit-stream and latency model, plus corner sequences.
module tb_kf_spi_host;

    localparam int DW = 16;
    localparam int CD = 4;
    localparam int NC = 5;
    localparam int CFG_LAT = 1 + 2 * CD * (1 + NC * DW) + NC * 2 * CD + 1;
    localparam int RD_LAT  = 2 * CD * DW + 2;
    localparam int NV = 8;

    typedef struct {
        logic [NC-1:0][DW-1:0] w;
        logic [DW-1:0]         rx;
        bit                    with_ready;
        bit                    scramble;
        int                    exp_lat;
        int                    exp_rises;
    } vec_t;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start_cfg = 1'b0;
    logic              slave_ready = 1'b0;
    logic [DW-1:0]     cfg_data = '0;
    logic [2:0]        cfg_idx;
    logic              busy;
    logic              cfg_done;
    logic [DW-1:0]     rx_data;
    logic              rx_valid;

    kf_spi_host_if spi ();

    kf_spi_host #(.DATA_W(DW), .CLK_DIV(CD), .N_CFG(NC)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start_cfg  (start_cfg),
        .cfg_data   (cfg_data),
        .cfg_idx    (cfg_idx),
        .slave_ready(slave_ready),
        .spi        (spi.master),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    vec_t                  tbl [NV];
    logic [NC-1:0][DW-1:0] words = '0;
    bit                    scramble = 1'b0;
    logic [2:0]            prev_idx = 3'b111;
    logic [DW-1:0]         rd_word = '0;
    int                    rises = 0;
    int                    falls = 0;
    int                    fall_base = 0;
    bit                    stream_q [$];
    bit                    exp_q [$];

    // Host side: present the indexed word, then optionally garble it.
    always @(negedge clk) begin
        if (cfg_idx != prev_idx)
            cfg_data = (cfg_idx < 3'(NC)) ? words[cfg_idx] : '0;
        else if (scramble)
            cfg_data = DW'($urandom);
        prev_idx = cfg_idx;
    end

    always @(posedge spi.sck) begin
        rises++;
        if (spi.ss) stream_q.push_back(spi.mosi);
    end

    always @(negedge spi.sck) falls++;

    always_comb begin
        int k;
        k = falls - fall_base;
        spi.miso = (k >= 0 && k < DW) ? rd_word[DW-1-k] : 1'b0;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void build_stream(input logic [NC-1:0][DW-1:0] w);
        exp_q.delete();
        exp_q.push_back(1'b1);
        for (int i = 0; i < NC; i++)
            for (int b = DW - 1; b >= 0; b--)
                exp_q.push_back(w[i][b]);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        start_cfg   = 1'b0;
        slave_ready = 1'b0;
        n_rst       = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_cfg(input bit with_ready, output int lat,
                          output int nr, output int ss_bad,
                          output int bit_err, output int first_idx);
        int rb;
        int qb;
        @(negedge clk);
        rb          = rises;
        qb          = stream_q.size();
        start_cfg   = 1'b1;
        slave_ready = with_ready;
        lat         = 0;
        ss_bad      = 0;
        first_idx   = -1;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start_cfg   = 1'b0;
            slave_ready = 1'b0;
            if (first_idx < 0 && cfg_idx != 3'b111) first_idx = int'(cfg_idx);
            if (busy && !spi.ss) ss_bad++;
        end while (!cfg_done && lat < 2000);
        nr      = rises - rb;
        bit_err = 0;
        if (stream_q.size() - qb != exp_q.size())
            bit_err = 1000 + stream_q.size() - qb;
        else
            for (int i = 0; i < exp_q.size(); i++)
                if (stream_q[qb+i] != exp_q[i]) bit_err++;
    endtask

    task automatic run_read(input logic [DW-1:0] w);
        int rb;
        int lat;
        @(negedge clk);
        rd_word     = w;
        fall_base   = falls;
        rb          = rises;
        slave_ready = 1'b1;
        lat         = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rx_valid && lat < 1000);
        check("rd_latency", lat, RD_LAT);
        check("rd_data", rx_data, w);
        check("rd_rises", rises - rb, DW);
        @(negedge clk);
        check("rd_valid_pulse", rx_valid, 0);
        check("rd_wait_busy", busy, 1);
        slave_ready = 1'b0;
        @(negedge clk);
        check("rd_idle_busy", busy, 0);
        check("rd_idle_ss", spi.ss, 0);
        repeat (3) @(negedge clk);
        check("rd_hold", rx_data, w);
    endtask

    initial begin
        int lat, nr, ss_bad, bit_err, fidx, bad, n;

        tbl[0] = '{w: {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111},
                   rx: 16'hA5C3, with_ready: 0, scramble: 0,
                   exp_lat: CFG_LAT, exp_rises: 1 + NC * DW};
        tbl[1] = '{w: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                   rx: 16'hFFFF, with_ready: 0, scramble: 1,
                   exp_lat: CFG_LAT, exp_rises: 1 + NC * DW};
        tbl[2] = '{w: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                   rx: 16'h0000, with_ready: 1, scramble: 0,
                   exp_lat: CFG_LAT, exp_rises: 1 + NC * DW};
        tbl[3] = '{w: {16'h8001, 16'h5555, 16'hAAAA, 16'h0001, 16'h8000},
                   rx: 16'h8001, with_ready: 1, scramble: 1,
                   exp_lat: CFG_LAT, exp_rises: 1 + NC * DW};
        for (int v = 4; v < NV; v++) begin
            for (int i = 0; i < NC; i++) tbl[v].w[i] = DW'($urandom);
            tbl[v].rx         = DW'($urandom);
            tbl[v].with_ready = 1'($urandom_range(0, 1));
            tbl[v].scramble   = 1'($urandom_range(0, 1));
            tbl[v].exp_lat    = CFG_LAT;
            tbl[v].exp_rises  = 1 + NC * DW;
        end

        repeat (3) @(negedge clk);
        check("rst_sck", spi.sck, 0);
        check("rst_ss", spi.ss, 0);
        check("rst_mosi", spi.mosi, 0);
        check("rst_idx", cfg_idx, 3'b111);
        check("rst_done", cfg_done, 0);
        check("rst_busy", busy, 0);
        check("rst_rx", {rx_valid, rx_data}, 0);
        n_rst = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (spi.sck || spi.ss || spi.mosi || busy || cfg_done ||
                cfg_idx != 3'b111 || rx_valid) bad++;
        end
        check("idle_after_reset", bad, 0);

        for (int v = 0; v < NV; v++) begin
            do_reset();
            words    = tbl[v].w;
            scramble = tbl[v].scramble;
            build_stream(words);
            do_cfg(tbl[v].with_ready, lat, nr, ss_bad, bit_err, fidx);
            check("cfg_latency", lat, tbl[v].exp_lat);
            check("cfg_rises", nr, tbl[v].exp_rises);
            check("cfg_ss_high", ss_bad, 0);
            check("cfg_stream", bit_err, 0);
            check("cfg_first_idx", fidx, 0);
            check("cfg_idx_after", cfg_idx, 3'b111);
            check("cfg_busy_after", busy, 0);
            run_read(tbl[v].rx);
        end

        n  = rises;
        @(negedge clk);
        start_cfg = 1'b1;
        @(negedge clk);
        start_cfg = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) bad++;
        end
        check("restart_busy", bad, 0);
        check("restart_sck", rises - n, 0);
        check("restart_done", cfg_done, 1);

        do_reset();
        words    = tbl[0].w;
        scramble = 1'b0;
        build_stream(words);
        @(negedge clk);
        start_cfg = 1'b1;
        @(negedge clk);
        start_cfg = 1'b0;
        n = 0;
        while (cfg_idx != 3'd2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_word2", cfg_idx, 2);
        repeat (20) @(negedge clk);
        n = 0;
        while (!spi.sck && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_sck_high", spi.sck, 1);
        #1 n_rst = 1'b0;
        #1;
        check("abort_ss", spi.ss, 0);
        check("abort_sck", spi.sck, 0);
        check("abort_done", cfg_done, 0);
        check("abort_busy", busy, 0);
        check("abort_idx", cfg_idx, 3'b111);
        @(negedge clk);
        n_rst = 1'b1;
        do_cfg(1'b0, lat, nr, ss_bad, bit_err, fidx);
        check("abort_cfg_latency", lat, CFG_LAT);
        check("abort_cfg_stream", bit_err, 0);
        check("abort_first_idx", fidx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
